// File: rtl/occ_gtpe2_rx_aligner.sv
// occ_gtpe2_rx_aligner: K28.5 byte aligner and LOS/ACQ/SYNC link FSM for the 2-lane GTPE2 RX stream.
// Define OCC_RX_ALIGNER_STATS_EN to build the err_cnt_o / los_cnt_o statistics counters.

module occ_gtpe2_rx_aligner #(
  parameter int g_ACQ_COMMAS    = 4,
  parameter int g_ERR_MAX       = 8,
  parameter int g_GOOD_RUN      = 64,
  parameter int g_COMMA_TIMEOUT = 256
) (
  input  logic        usrclk_i,
  input  logic        rst_i,
  input  logic        rxresetdone_i,
  input  logic [15:0] rxdata_i,
  input  logic [1:0]  rxcharisk_i,
  input  logic [1:0]  rxdisperr_i,
  input  logic [1:0]  rxnotintable_i,
  output logic [15:0] data_o,
  output logic [1:0]  charisk_o,
  output logic        valid_o,
  output logic        link_up_o,
  output logic        byte_swap_o,
  output logic [15:0] err_cnt_o,
  output logic [7:0]  los_cnt_o
);

  localparam int LP_ACQ_W = $clog2(g_ACQ_COMMAS + 1);
  localparam int LP_WIN_W = $clog2(g_ERR_MAX + 1);
  localparam int LP_RUN_W = $clog2(g_GOOD_RUN + 1);
  localparam int LP_TO_W  = $clog2(g_COMMA_TIMEOUT + 1);

  localparam logic [LP_ACQ_W-1:0] LP_ACQ_ONE  = LP_ACQ_W'(1);
  localparam logic [LP_ACQ_W-1:0] LP_ACQ_LAST = LP_ACQ_W'(g_ACQ_COMMAS - 1);
  localparam logic [LP_WIN_W-1:0] LP_WIN_LAST = LP_WIN_W'(g_ERR_MAX - 1);
  localparam logic [LP_RUN_W-1:0] LP_RUN_LAST = LP_RUN_W'(g_GOOD_RUN - 1);
  localparam logic [LP_TO_W-1:0]  LP_TO_LAST  = LP_TO_W'(g_COMMA_TIMEOUT - 1);
  localparam logic [7:0]          LP_K28_5    = 8'hBC;

  typedef enum logic [1:0] {ST_LOS, ST_ACQ, ST_SYNC} state_t;

  // Input stage: current raw word plus the high byte of the previous one
  logic [15:0] r_cur_data;
  logic [1:0]  r_cur_k, r_cur_de, r_cur_nt;
  logic        r_cur_vld;
  logic [7:0]  r_prev_hi;
  logic        r_prev_k_hi, r_prev_bad_hi;

  always_ff @(posedge usrclk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      r_cur_data    <= '0;
      r_cur_k       <= '0;
      r_cur_de      <= '0;
      r_cur_nt      <= '0;
      r_cur_vld     <= 1'b0;
      r_prev_hi     <= '0;
      r_prev_k_hi   <= 1'b0;
      r_prev_bad_hi <= 1'b0;
    end else begin
      r_cur_data    <= rxdata_i;
      r_cur_k       <= rxcharisk_i;
      r_cur_de      <= rxdisperr_i;
      r_cur_nt      <= rxnotintable_i;
      r_cur_vld     <= rxresetdone_i;
      r_prev_hi     <= r_cur_data[15:8];
      r_prev_k_hi   <= r_cur_k[1];
      r_prev_bad_hi <= r_cur_de[1] | r_cur_nt[1];
    end
  end

  state_t              r_state, w_state_nxt;
  logic                r_swap, w_swap_nxt;
  logic [LP_ACQ_W-1:0] r_acq_cnt, w_acq_nxt;
  logic [LP_WIN_W-1:0] r_err_win, w_win_nxt;
  logic [LP_RUN_W-1:0] r_good_run, w_run_nxt;
  logic [LP_TO_W-1:0]  r_to_cnt, w_to_nxt;
  logic                w_valid_nxt, w_drop;

  logic [1:0]  w_cur_bad;
  logic [15:0] w_al_data;
  logic [1:0]  w_al_k, w_al_bad;
  logic        w_word_err, w_al_comma, w_comma_hi, w_comma_lo, w_wrong_comma, w_timeout;

  assign w_cur_bad     = r_cur_de | r_cur_nt;
  assign w_al_data     = r_swap ? {r_cur_data[7:0], r_prev_hi} : r_cur_data;
  assign w_al_k        = r_swap ? {r_cur_k[0], r_prev_k_hi}    : r_cur_k;
  assign w_al_bad      = r_swap ? {w_cur_bad[0], r_prev_bad_hi} : w_cur_bad;
  assign w_word_err    = |w_al_bad;
  assign w_al_comma    = r_cur_vld & w_al_k[1] & (w_al_data[15:8] == LP_K28_5);
  assign w_comma_hi    = r_cur_vld & r_cur_k[1] & (r_cur_data[15:8] == LP_K28_5);
  assign w_comma_lo    = r_cur_vld & r_cur_k[0] & (r_cur_data[7:0] == LP_K28_5);
  // A raw hi-lane comma under swap=1 lands in byte [7:0] of the next aligned word
  assign w_wrong_comma = r_swap ? w_comma_hi : w_comma_lo;
  assign w_timeout     = (r_to_cnt == LP_TO_LAST) & ~w_al_comma;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_swap_nxt  = r_swap;
    w_acq_nxt   = r_acq_cnt;
    w_win_nxt   = r_err_win;
    w_run_nxt   = r_good_run;
    w_to_nxt    = (r_state == ST_LOS || w_al_comma) ? '0 : r_to_cnt + LP_TO_W'(1);
    w_drop      = 1'b0;
    case (r_state)
      ST_LOS: begin
        if (w_comma_hi && !w_cur_bad[1]) begin
          w_swap_nxt  = 1'b0;
          w_acq_nxt   = LP_ACQ_ONE;
          w_state_nxt = ST_ACQ;
        end else if (w_comma_lo && !w_cur_bad[0]) begin
          w_swap_nxt  = 1'b1;
          w_acq_nxt   = LP_ACQ_ONE;
          w_state_nxt = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (w_word_err || w_wrong_comma || w_timeout) begin
          w_state_nxt = ST_LOS;
          w_acq_nxt   = '0;
          w_to_nxt    = '0;
        end else if (w_al_comma) begin
          if (r_acq_cnt >= LP_ACQ_LAST) begin
            w_state_nxt = ST_SYNC;
            w_acq_nxt   = '0;
            w_win_nxt   = '0;
            w_run_nxt   = '0;
          end else begin
            w_acq_nxt = r_acq_cnt + LP_ACQ_W'(1);
          end
        end
      end
      ST_SYNC: begin
        if (w_word_err) begin
          w_run_nxt = '0;
          if (r_err_win == LP_WIN_LAST) w_drop = 1'b1;
          else                          w_win_nxt = r_err_win + LP_WIN_W'(1);
        end else if (r_good_run == LP_RUN_LAST) begin
          w_run_nxt = '0;
          if (r_err_win != '0) w_win_nxt = r_err_win - LP_WIN_W'(1);
        end else begin
          w_run_nxt = r_good_run + LP_RUN_W'(1);
        end
        if (w_wrong_comma || w_timeout) w_drop = 1'b1;
      end
      default: w_state_nxt = ST_LOS;
    endcase
    if (w_drop || !rxresetdone_i) begin
      w_state_nxt = ST_LOS;
      w_acq_nxt   = '0;
      w_win_nxt   = '0;
      w_run_nxt   = '0;
      w_to_nxt    = '0;
    end
    if (!rxresetdone_i) w_swap_nxt = r_swap;
    w_valid_nxt = (r_state == ST_SYNC) && (w_state_nxt == ST_SYNC) && !w_word_err && r_cur_vld;
  end

  always_ff @(posedge usrclk_i) begin
    if (rst_i) begin
      r_state    <= ST_LOS;
      r_swap     <= 1'b0;
      r_acq_cnt  <= '0;
      r_err_win  <= '0;
      r_good_run <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_swap     <= w_swap_nxt;
      r_acq_cnt  <= w_acq_nxt;
      r_err_win  <= w_win_nxt;
      r_good_run <= w_run_nxt;
      r_to_cnt   <= w_to_nxt;
    end
  end

  logic [15:0] r_data_o;
  logic [1:0]  r_charisk_o;
  logic        r_valid_o;

  always_ff @(posedge usrclk_i) begin
    // NOTE: the data path is reset too, so data_o reads 0 after reset rather than stale words.
    if (rst_i) begin
      r_data_o    <= '0;
      r_charisk_o <= '0;
      r_valid_o   <= 1'b0;
    end else begin
      r_data_o    <= w_al_data;
      r_charisk_o <= w_al_k;
      r_valid_o   <= w_valid_nxt;
    end
  end

  assign data_o      = r_data_o;
  assign charisk_o   = r_charisk_o;
  assign valid_o     = r_valid_o;
  assign link_up_o   = (r_state == ST_SYNC);
  assign byte_swap_o = r_swap;

`ifdef OCC_RX_ALIGNER_STATS_EN
  logic [15:0] r_err_cnt;
  logic [7:0]  r_los_cnt;
  logic        w_err_inc, w_los_inc;

  assign w_err_inc = (r_state == ST_SYNC) & w_word_err;
  assign w_los_inc = (r_state == ST_SYNC) & (w_state_nxt != ST_SYNC);

  always_ff @(posedge usrclk_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
      r_los_cnt <= '0;
    end else begin
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 16'd1;
      if (w_los_inc && (r_los_cnt != '1)) r_los_cnt <= r_los_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
  assign los_cnt_o = r_los_cnt;
`else
  assign err_cnt_o = '0;
  assign los_cnt_o = '0;
`endif

endmodule

// File: tb/tb_occ_gtpe2_rx_aligner.sv
// tb_occ_gtpe2_rx_aligner: directed self-checking bench for occ_gtpe2_rx_aligner.
// Statistics expectations follow OCC_RX_ALIGNER_STATS_EN (0 when the macro is undefined).

module tb_occ_gtpe2_rx_aligner;

`ifdef OCC_RX_ALIGNER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic [15:0] rxdata;
  logic [1:0]  rxk, rxde, rxnt;
  logic [15:0] data_o;
  logic [1:0]  charisk_o;
  logic        valid_o, link_up_o, byte_swap_o;
  logic [15:0] err_cnt_o;
  logic [7:0]  los_cnt_o;

  occ_gtpe2_rx_aligner dut (
    .usrclk_i       (clk),
    .rst_i          (rst),
    .rxresetdone_i  (rd),
    .rxdata_i       (rxdata),
    .rxcharisk_i    (rxk),
    .rxdisperr_i    (rxde),
    .rxnotintable_i (rxnt),
    .data_o         (data_o),
    .charisk_o      (charisk_o),
    .valid_o        (valid_o),
    .link_up_o      (link_up_o),
    .byte_swap_o    (byte_swap_o),
    .err_cnt_o      (err_cnt_o),
    .los_cnt_o      (los_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  k;
    logic [1:0]  de;
    logic [1:0]  nt;
    logic        exp_valid;
    logic        exp_link;
  } vec_t;

  vec_t tbl [8];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   j;
  bit   shifted;
  int   comma_until;

  function automatic int st(input int v);
    return STATS ? v : 0;
  endfunction

  // Reference stream: comma word every 32 words, counter-style data otherwise
  function automatic logic [17:0] sw(input int idx);
    if (idx < comma_until && (idx % 32) == 0) return {2'b10, 16'hBC95};
    return {2'b00, 16'(idx) ^ 16'h3C00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] k, input logic [1:0] de,
                      input logic [1:0] nt, input logic rdone);
    rxdata = d;
    rxk    = k;
    rxde   = de;
    rxnt   = nt;
    rd     = rdone;
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input logic [1:0] de, input logic rdone);
    logic [17:0] a, b;
    a = sw(j);
    b = sw(j + 1);
    if (!shifted) send(a[15:0], a[17:16], de, 2'b00, rdone);
    else          send({b[7:0], a[15:8]}, {b[16], a[17]}, de, 2'b00, rdone);
    j++;
  endtask

  task automatic apply_reset(input string name);
    rst = 1'b1;
    send(16'h0000, 2'b00, 2'b00, 2'b00, 1'b1);
    send(16'h0000, 2'b00, 2'b00, 2'b00, 1'b1);
    send(16'h0000, 2'b00, 2'b00, 2'b00, 1'b1);
    check({name, "_data"},  data_o,      0);
    check({name, "_k"},     charisk_o,   0);
    check({name, "_valid"}, valid_o,     0);
    check({name, "_link"},  link_up_o,   0);
    check({name, "_swap"},  byte_swap_o, 0);
    check({name, "_err"},   err_cnt_o,   0);
    check({name, "_los"},   los_cnt_o,   0);
    rst = 1'b0;
  endtask

  task automatic relock(input string name);
    int k;
    k = 0;
    while (!link_up_o && k < 400) begin
      send_stream(2'b00, 1'b1);
      k++;
    end
    check(name, link_up_o, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] w;
    int t_comma, t_drop, k;

    tbl[0] = '{16'h1234, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[1] = '{16'h5678, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[2] = '{16'h9ABC, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[3] = '{16'hBC95, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[4] = '{16'h0102, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1};
    tbl[5] = '{16'h0304, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[6] = '{16'h00BC, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[7] = '{16'h0506, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

    rst = 1'b1; rd = 1'b1; rxdata = '0; rxk = '0; rxde = '0; rxnt = '0;
    shifted = 1'b0; j = 0; comma_until = 1 << 30;

    // Lock on an aligned stream, check 2-cycle pass-through
    apply_reset("rst0");
    for (int s = 0; s <= 97; s++) begin
      send_stream(2'b00, 1'b1);
      if (s >= 1) begin
        w = sw(s - 1);
        check("t1_data", data_o, w[15:0]);
        check("t1_k", charisk_o, w[17:16]);
      end
      if (s == 96) check("t1_link_before_4th", link_up_o, 0);
      if (s == 97) check("t1_link_after_4th", link_up_o, 1);
    end
    send_stream(2'b00, 1'b1);
    check("t1_valid", valid_o, 1);
    check("t1_swap", byte_swap_o, 0);

    // Eight disparity errors two words apart
    for (int p = 0; p < 8; p++) begin
      send_stream(2'b01, 1'b1);
      check("t3_valid_clean", valid_o, 1);
      send_stream(2'b00, 1'b1);
      check("t3_valid_err", valid_o, 0);
      check("t3_link", link_up_o, (p < 7) ? 1 : 0);
    end
    check("t3_err_cnt", err_cnt_o, st(8));
    check("t3_los_cnt", los_cnt_o, st(1));

    // Table vectors in SYNC, ending with a wrong-lane comma
    relock("d_relock");
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) send(tbl[i].data, tbl[i].k, tbl[i].de, tbl[i].nt, 1'b1);
      else       send(16'h0708, 2'b00, 2'b00, 2'b00, 1'b1);
      if (i > 0) begin
        check("tbl_data",  data_o,    tbl[i-1].data);
        check("tbl_k",     charisk_o, tbl[i-1].k);
        check("tbl_valid", valid_o,   tbl[i-1].exp_valid);
        check("tbl_link",  link_up_o, tbl[i-1].exp_link);
      end
    end
    check("tbl_err_cnt", err_cnt_o, st(10));
    check("tbl_los_cnt", los_cnt_o, st(2));

    // One error then 64 clean words, repeated: window must keep draining
    relock("t4_relock");
    for (int r = 0; r < 20; r++) begin
      send_stream(2'b10, 1'b1);
      repeat (64) send_stream(2'b00, 1'b1);
      check("t4_link", link_up_o, 1);
    end
    check("t4_err_cnt", err_cnt_o, st(30));

    // Comma timeout: measured from the last comma on data_o to link drop
    while (((j - 1) % 32) != 0) send_stream(2'b00, 1'b1);
    comma_until = j;
    t_comma = -1; t_drop = -1; k = 0;
    while (k < 400 && t_drop < 0) begin
      send_stream(2'b00, 1'b1);
      k++;
      if (data_o == 16'hBC95 && charisk_o == 2'b10) t_comma = k;
      if (!link_up_o) t_drop = k;
    end
    check("t5_timeout_cycles", 32'(t_drop - t_comma), 256);
    check("t5_los_cnt", los_cnt_o, st(3));

    // Mid-operation reset, then a stream shifted by one byte
    apply_reset("rst1");
    shifted = 1'b1; j = 0; comma_until = 1 << 30;
    for (int s = 0; s <= 97; s++) begin
      send_stream(2'b00, 1'b1);
      if (s >= 2) begin
        w = sw(s - 1);
        check("t2_data", data_o, w[15:0]);
        check("t2_k", charisk_o, w[17:16]);
      end
      if (s == 96) check("t2_link_before_4th", link_up_o, 0);
      if (s == 97) begin
        check("t2_link_after_4th", link_up_o, 1);
        check("t2_comma_data", data_o, 16'hBC95);
        check("t2_comma_k", charisk_o, 2'b10);
        check("t2_swap", byte_swap_o, 1);
      end
    end
    send_stream(2'b00, 1'b1);
    check("t2_valid", valid_o, 1);

    // One-cycle rxresetdone drop mid-SYNC
    while (j < 110) send_stream(2'b00, 1'b1);
    send_stream(2'b00, 1'b0);
    check("t6_link", link_up_o, 0);
    check("t6_valid", valid_o, 0);
    check("t6_swap_held", byte_swap_o, 1);
    check("t6_los_cnt", los_cnt_o, st(1));
    while (j <= 225) begin
      send_stream(2'b00, 1'b1);
      if (j - 1 == 224) check("t6_link_before_4th", link_up_o, 0);
      if (j - 1 == 225) check("t6_relock", link_up_o, 1);
    end
    check("t6_swap", byte_swap_o, 1);
    check("t6_err_cnt", err_cnt_o, st(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
